// File: rtl/event_stretcher_pkg.sv
// event_stretcher_pkg: state encoding and default sizing shared by the event stretcher slice.
package event_stretcher_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;
    localparam int HOLD_CYCLES_DEF = 64;
    localparam int GAP_CYCLES_DEF  = 64;
    localparam int CNT_W_DEF       = 25;
    localparam int PEND_W_DEF      = 4;
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: saturating up/down counter; an increment at full is dropped and flagged.
module sat_updown_counter
    import event_stretcher_pkg::*;
#(
    parameter int W = PEND_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         overflow
);
    logic [W-1:0] count_q, count_d;
    logic         overflow_q, overflow_d;
    assign full     = &count_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    always_comb begin
        count_d    = inc && !dec ? (full ? count_q : count_q + 1'b1) :
                     dec && !inc ? count_q - 1'b1 : count_q;
        overflow_d = inc && !dec && full;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: rtl/event_stretcher.sv
// event_stretcher: turns event strobes into fixed-width active-low pulses with an enforced
// high gap, queueing events that arrive while a pulse is in flight.
module event_stretcher
    import event_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PEND_W      = PEND_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              evt,
    output logic              out_n,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    state_e           state_q;
    logic [CNT_W-1:0] tmr_q;
    logic             out_n_q, busy_q;
    logic             pend_full, pend_nz, tmr_zero, inc, dec;
    assign pend_nz  = pend_full || pending != '0;
    assign tmr_zero = tmr_q == '0;
    // An IDLE event starts the pulse directly; every other event is queued.
    assign inc = evt && !(state_q == IDLE && !pend_nz);
    assign dec = pend_nz && (state_q == IDLE || (state_q == GAP && tmr_zero));
    assign out_n = out_n_q;
    assign busy  = busy_q;
    sat_updown_counter #(.W(PEND_W)) u_pend (
        .clock    (clock),
        .reset    (reset),
        .inc      (inc),
        .dec      (dec),
        .count    (pending),
        .full     (pend_full),
        .overflow (overflow)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            out_n_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (evt || pend_nz) begin
                    state_q <= ACTIVE;
                    tmr_q   <= HOLD_LOAD;
                    out_n_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                ACTIVE: if (tmr_zero) begin
                    state_q <= GAP;
                    tmr_q   <= GAP_LOAD;
                    out_n_q <= 1'b1;
                end else begin
                    tmr_q <= tmr_q - 1'b1;
                end
                GAP: if (tmr_zero && pend_nz) begin
                    state_q <= ACTIVE;
                    tmr_q   <= HOLD_LOAD;
                    out_n_q <= 1'b0;
                end else if (tmr_zero) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    tmr_q <= tmr_q - 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    tmr_q   <= '0;
                    out_n_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_event_stretcher.sv
// tb_event_stretcher: directed checks of pulse timing, queueing, saturation and reset.
module tb_event_stretcher;
    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int PW   = 4;
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          evt   = 1'b0;
    logic          out_n, busy, overflow;
    logic [PW-1:0] pending;
    int            checks = 0;
    int            errors = 0;
    int            pulses = 0;
    int            base, ovf, cyc;

    event_stretcher #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(8), .PEND_W(PW)) dut (
        .clock    (clock),
        .reset    (reset),
        .evt      (evt),
        .out_n    (out_n),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clock = ~clock;
    always @(negedge out_n) pulses++;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        step;
        step;
        check("rst_out_n", 32'(out_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        step;

        // single strobe: low 8 cycles, high gap 4, busy 12
        evt = 1'b1;
        step;
        evt = 1'b0;
        check("single_start_out_n", 32'(out_n), 0);
        check("single_start_busy", 32'(busy), 1);
        check("single_start_pending", 32'(pending), 0);
        for (int i = 1; i < HOLD; i++) begin
            step;
            check("single_low", 32'(out_n), 0);
        end
        step;
        check("single_rise_out_n", 32'(out_n), 1);
        check("single_gap_busy", 32'(busy), 1);
        repeat (GAP - 1) step;
        check("single_gap_end_busy", 32'(busy), 1);
        step;
        check("single_idle_busy", 32'(busy), 0);
        check("single_idle_out_n", 32'(out_n), 1);
        check("single_idle_pending", 32'(pending), 0);

        // three strobes 5 cycles apart, replayed back to back
        base = pulses;
        for (int j = 0; j <= 36; j++) begin
            evt = (j == 0 || j == 5 || j == 10);
            step;
            evt = 1'b0;
            check("three_out_n", 32'(out_n),
                  32'(!((j < 8) || (j >= 12 && j < 20) || (j >= 24 && j < 32))));
            check("three_busy", 32'(busy), 32'(j < 36));
            if (j == 5)  check("three_pend_1", 32'(pending), 1);
            if (j == 10) check("three_pend_2", 32'(pending), 2);
            if (j == 12) check("three_pend_dec", 32'(pending), 1);
            if (j == 24) check("three_pend_0", 32'(pending), 0);
        end
        check("three_pulses", 32'(pulses - base), 3);

        // event in the final gap cycle with nothing queued: goes IDLE with one queued
        evt = 1'b1;
        step;
        evt = 1'b0;
        repeat (11) step;
        evt = 1'b1;
        step;
        evt = 1'b0;
        check("lastgap_pending", 32'(pending), 1);
        check("lastgap_busy", 32'(busy), 0);
        check("lastgap_out_n", 32'(out_n), 1);
        step;
        check("lastgap_replay_out_n", 32'(out_n), 0);
        check("lastgap_replay_busy", 32'(busy), 1);
        check("lastgap_replay_pending", 32'(pending), 0);
        repeat (12) step;
        check("lastgap_drained", 32'(busy), 0);

        // evt held 20 cycles: saturate at 15, three dropped, 17 pulses total
        base = pulses;
        ovf = 0;
        evt = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step;
            ovf += int'(overflow);
            if (j == 12) check("sat_pend_simul", 32'(pending), 11);
            if (j == 16) check("sat_pend_full", 32'(pending), 15);
            if (j == 16) check("sat_ovf_quiet", 32'(overflow), 0);
            if (j == 17) check("sat_ovf_first", 32'(overflow), 1);
        end
        evt = 1'b0;
        check("sat_pend_hold", 32'(pending), 15);
        check("sat_ovf_count", 32'(ovf), 3);
        step;
        check("sat_ovf_clear", 32'(overflow), 0);
        cyc = 20;
        while (busy && cyc < 400) begin
            step;
            cyc++;
        end
        check("sat_idle_edge", 32'(cyc), 204);
        check("sat_pulses", 32'(pulses - base), 17);

        // event coinciding with the gap-end decrement, then reset mid-pulse
        evt = 1'b1;
        step;
        step;
        step;
        evt = 1'b0;
        check("simul_pend_pre", 32'(pending), 2);
        repeat (9) step;
        evt = 1'b1;
        step;
        check("simul_pend_keep", 32'(pending), 2);
        check("simul_out_n", 32'(out_n), 0);
        check("simul_busy", 32'(busy), 1);
        step;
        evt = 1'b0;
        check("simul_pend_3", 32'(pending), 3);
        check("simul_active", 32'(out_n), 0);
        reset = 1'b1;
        step;
        check("midrst_out_n", 32'(out_n), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_pending", 32'(pending), 0);
        check("midrst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        base = pulses;
        repeat (30) step;
        check("midrst_no_pulses", 32'(pulses - base), 0);
        check("midrst_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
